// File: rtl/conv_encoder_1_2.sv
// Rate-1/2 feed-forward convolutional encoder, constraint length K, octal generators.
// One bit in per accepted cycle, one registered 2-bit symbol out one edge later.
module conv_encoder_1_2 #(
  parameter int unsigned K      = 7,
  parameter int unsigned G0_OCT = 'o171,
  parameter int unsigned G1_OCT = 'o133
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_load,
  input  logic [K-2:0] seed_value,
  input  logic         in_valid,
  input  logic         in_bit,
  output logic         out_valid,
  output logic [1:0]   out_sym
);

  localparam int unsigned M = K - 1;
  localparam logic [K-1:0] MASK0 = G0_OCT[K-1:0];
  localparam logic [K-1:0] MASK1 = G1_OCT[K-1:0];

  logic [M-1:0] state_q, state_d;
  logic [1:0]   out_sym_q, out_sym_d;
  logic         out_valid_q, out_valid_d;
  logic [K-1:0] taps;

  // taps[K-1] is the incoming bit, taps[0] the oldest remembered bit
  assign taps = {in_bit, state_q};

  always_comb begin
    state_d     = state_q;
    out_sym_d   = out_sym_q;
    out_valid_d = 1'b0;
    if (seed_load) begin
      state_d = seed_value;
    end else if (in_valid) begin
      out_sym_d   = {^(taps & MASK0), ^(taps & MASK1)};
      out_valid_d = 1'b1;
      state_d     = {in_bit, state_q[M-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= '0;
      out_sym_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_sym_q   <= out_sym_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;

endmodule

// File: tb/tb_conv_encoder_1_2.sv
// Directed bench for conv_encoder_1_2 in the K=7, (171,133) octal configuration.
module tb_conv_encoder_1_2;

  logic       clk;
  logic       rst;
  logic       seed_load;
  logic [5:0] seed_value;
  logic       in_valid;
  logic       in_bit;
  logic       out_valid;
  logic [1:0] out_sym;

  int unsigned tests_run;
  int unsigned tests_failed;

  logic [5:0] mst;

  conv_encoder_1_2 #(.K(7), .G0_OCT('o171), .G1_OCT('o133)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed_value(seed_value),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_sym   (out_sym)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // golden parity: 171 octal = 1111001b, 133 octal = 1011011b over {bit, state}
  function automatic logic [1:0] model_sym(input logic b, input logic [5:0] st);
    logic [6:0] r;
    r = {b, st};
    return {^(r & 7'b1111001), ^(r & 7'b1011011)};
  endfunction

  task automatic send(input logic b);
    in_valid  = 1'b1;
    in_bit    = b;
    seed_load = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    seed_load = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; seed_load = 1'b0; seed_value = '0; in_valid = 1'b0; in_bit = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_sym !== 2'b00) begin
      $display("FAIL reset: valid=%b sym=%b, want valid=0 sym=00", out_valid, out_sym);
      tests_failed++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zeros();
    int unsigned bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      send(1'b0);
      if (out_valid !== 1'b1 || out_sym !== 2'b00) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      $display("FAIL zeros: %0d of 32 symbols wrong, want valid=1 sym=00", bad);
      tests_failed++;
    end
  endtask

  task automatic test_ones();
    logic [1:0] exp_syms [8];
    exp_syms = '{2'b11, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11};
    for (int i = 0; i < 8; i++) begin
      send(1'b1);
      tests_run++;
      if (out_valid !== 1'b1 || out_sym !== exp_syms[i]) begin
        $display("FAIL ones[%0d]: valid=%b sym=%b, want valid=1 sym=%b",
                 i, out_valid, out_sym, exp_syms[i]);
        tests_failed++;
      end
    end
  endtask

  task automatic test_seed();
    seed_load  = 1'b1;
    seed_value = 6'b111111;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_sym !== 2'b11) begin
      $display("FAIL seed_load: valid=%b sym=%b, want valid=0 sym=11 (held)", out_valid, out_sym);
      tests_failed++;
    end
    send(1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_sym !== 2'b00) begin
      $display("FAIL seed_bit0: valid=%b sym=%b, want valid=1 sym=00", out_valid, out_sym);
      tests_failed++;
    end
    // state is now 011111; a further 0 gives r=0011111 -> 10
    send(1'b0);
    tests_run++;
    if (out_sym !== 2'b10) begin
      $display("FAIL seed_next: sym=%b, want 10", out_sym);
      tests_failed++;
    end
  endtask

  task automatic test_seed_priority();
    seed_load  = 1'b1;
    seed_value = 6'b000000;
    in_valid   = 1'b1;
    in_bit     = 1'b1;
    @(posedge clk);
    #1;
    seed_load = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || out_sym !== 2'b10) begin
      $display("FAIL seed_priority: valid=%b sym=%b, want valid=0 sym=10", out_valid, out_sym);
      tests_failed++;
    end
    send(1'b1);
    tests_run++;
    if (out_sym !== 2'b11) begin
      $display("FAIL seed_priority_state: sym=%b, want 11", out_sym);
      tests_failed++;
    end
    mst = 6'b100000;
  endtask

  task automatic test_random();
    logic [15:0] lfsr;
    logic        b;
    logic [1:0]  exp;
    int unsigned bad;
    lfsr = 16'hACE1;
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      b    = lfsr[0];
      exp  = model_sym(b, mst);
      mst  = {b, mst[5:1]};
      send(b);
      if (out_valid !== 1'b1 || out_sym !== exp) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      $display("FAIL random: %0d of 100 symbols wrong vs model", bad);
      tests_failed++;
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bits;
    logic [1:0] exp;
    logic [1:0] held;
    bits = 8'b1011_0110;
    for (int i = 0; i < 8; i++) begin
      exp = model_sym(bits[i], mst);
      mst = {bits[i], mst[5:1]};
      send(bits[i]);
      tests_run++;
      if (out_valid !== 1'b1 || out_sym !== exp) begin
        $display("FAIL gap_bit[%0d]: valid=%b sym=%b, want valid=1 sym=%b", i, out_valid, out_sym, exp);
        tests_failed++;
      end
      held = exp;
      for (int g = 0; g <= (i % 3); g++) begin
        idle();
        tests_run++;
        if (out_valid !== 1'b0 || out_sym !== held) begin
          $display("FAIL gap_idle[%0d]: valid=%b sym=%b, want valid=0 sym=%b", i, out_valid, out_sym, held);
          tests_failed++;
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    send(1'b1);
    send(1'b1);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_sym !== 2'b00) begin
      $display("FAIL async_reset: valid=%b sym=%b, want valid=0 sym=00", out_valid, out_sym);
      tests_failed++;
    end
    @(negedge clk);
    rst = 1'b1;
    send(1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_sym !== 2'b11) begin
      $display("FAIL post_reset_bit: valid=%b sym=%b, want valid=1 sym=11", out_valid, out_sym);
      tests_failed++;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mst          = '0;
    test_reset();
    test_zeros();
    test_ones();
    test_seed();
    test_seed_priority();
    test_random();
    test_gaps();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
